// File: rtl/grid_pkg.sv
// Shared types and colour constants for the grid colour controller.
package grid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    A     = 2'd1,
    B     = 2'd2,
    WIN   = 2'd3
  } cell_state_t;

  localparam logic [2:0] LINE   = 3'b000;
  localparam logic [2:0] BG     = 3'b001;
  localparam logic [2:0] CURSOR = 3'b010;

  localparam int unsigned POS_W  = 16;
  localparam int unsigned CELL_W = 4;

endpackage

// File: rtl/grid_color_controller_if.sv
// Pixel position, board control and colour output bundle for the grid controller.
interface grid_color_controller_if #(
  parameter int unsigned COLOR_W = 3
);
  logic [15:0]        Xpos;
  logic [15:0]        Ypos;
  logic               frame_start;
  logic [3:0]         cursor_col;
  logic [3:0]         cursor_row;
  logic               cell_we;
  logic [3:0]         cell_col;
  logic [3:0]         cell_row;
  logic [1:0]         cell_data;
  logic               clear_board;
  logic [COLOR_W-1:0] Red;
  logic [COLOR_W-1:0] Green;
  logic [COLOR_W-1:0] Blue;

  modport master (
    output Xpos, Ypos, frame_start, cursor_col, cursor_row,
    output cell_we, cell_col, cell_row, cell_data, clear_board,
    input  Red, Green, Blue
  );

  modport slave (
    input  Xpos, Ypos, frame_start, cursor_col, cursor_row,
    input  cell_we, cell_col, cell_row, cell_data, clear_board,
    output Red, Green, Blue
  );
endinterface

// File: rtl/grid_blink_timer.sv
// Counts frame pulses and toggles the cursor blink phase every BLINK_FRAMES frames.
module grid_blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_start,
  output logic blink_on
);
  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      blink_on <= 1'b1;
    end else if (frame_start) begin
      if (count == CNT_W'(BLINK_FRAMES - 1)) begin
        count    <= '0;
        blink_on <= ~blink_on;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/grid_color_controller.sv
// Two-stage pixel pipeline mapping a screen position onto a board grid and colouring it.
module grid_color_controller
  import grid_pkg::*;
#(
  parameter int unsigned COLS         = 3,
  parameter int unsigned ROWS         = 3,
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned COLOR_W      = 3,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  grid_color_controller_if.slave  bus
);
  localparam int unsigned CW    = H_RES / COLS;
  localparam int unsigned CH    = V_RES / ROWS;
  localparam int unsigned NCELL = COLS * ROWS;
  localparam int unsigned IDX_W = (NCELL > 1) ? $clog2(NCELL) : 1;

  localparam logic [COLOR_W-1:0] ONES  = '1;
  localparam logic [COLOR_W-1:0] C_LN  = COLOR_W'(LINE);
  localparam logic [COLOR_W-1:0] C_BG  = COLOR_W'(BG);
  localparam logic [COLOR_W-1:0] C_CUR = COLOR_W'(CURSOR);

  logic              blink_on;
  logic              line_c, oob_c;
  logic [CELL_W-1:0] col_c, row_c;
  logic              line_q, oob_q;
  logic [CELL_W-1:0] col_q, row_q;
  cell_state_t       cells [NCELL];
  logic              wr_ok_c;
  logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
  cell_state_t       state_c;
  logic              cursor_hit_c;
  logic [COLOR_W-1:0] mark_r_c, mark_g_c, mark_b_c;
  logic [COLOR_W-1:0] red_c, green_c, blue_c;

  grid_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .clk         (clk),
    .rst         (rst),
    .frame_start (bus.frame_start),
    .blink_on    (blink_on)
  );

  // Stage 1: grid-line detect and cell index by threshold compare (clamps naturally at the last cell)
  always_comb begin
    line_c = 1'b0;
    col_c  = '0;
    row_c  = '0;
    oob_c  = (32'(bus.Xpos) >= H_RES) || (32'(bus.Ypos) >= V_RES);
    for (int unsigned k = 1; k < COLS; k++) begin
      if (32'(bus.Xpos) >= k * CW) col_c = CELL_W'(k);
      if (32'(bus.Xpos) == k * CW) line_c = 1'b1;
    end
    for (int unsigned k = 1; k < ROWS; k++) begin
      if (32'(bus.Ypos) >= k * CH) row_c = CELL_W'(k);
      if (32'(bus.Ypos) == k * CH) line_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= 1'b0;
      oob_q  <= 1'b0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      line_q <= line_c;
      oob_q  <= oob_c;
      col_q  <= col_c;
      row_q  <= row_c;
    end
  end

  // Board state: clear beats a write, out-of-range writes are dropped
  assign wr_ok_c  = bus.cell_we && (32'(bus.cell_col) < COLS) && (32'(bus.cell_row) < ROWS);
  assign wr_idx_c = IDX_W'(32'(bus.cell_row) * COLS + 32'(bus.cell_col));

  always_ff @(posedge clk) begin
    if (rst || bus.clear_board) begin
      cells <= '{default: EMPTY};
    end else if (wr_ok_c) begin
      cells[wr_idx_c] <= cell_state_t'(bus.cell_data);
    end
  end

  assign rd_idx_c     = IDX_W'(32'(row_q) * COLS + 32'(col_q));
  assign state_c      = cells[rd_idx_c];
  assign cursor_hit_c = blink_on
                     && (32'(bus.cursor_col) < COLS) && (32'(bus.cursor_row) < ROWS)
                     && (bus.cursor_col == col_q) && (bus.cursor_row == row_q);

  // Stage 2: colour priority out-of-area > line > cursor > cell mark
  always_comb begin
    mark_r_c = '0;
    mark_g_c = '0;
    mark_b_c = '0;
    case (state_c)
      A:       mark_r_c = ONES;
      B:       mark_b_c = ONES;
      WIN:     mark_g_c = ONES;
      default: begin
        mark_r_c = C_BG;
        mark_g_c = C_BG;
        mark_b_c = C_BG;
      end
    endcase
    red_c   = mark_r_c;
    green_c = mark_g_c;
    blue_c  = mark_b_c;
    if (oob_q) begin
      red_c   = '0;
      green_c = '0;
      blue_c  = '0;
    end else if (line_q) begin
      red_c   = C_LN;
      green_c = C_LN;
      blue_c  = C_LN;
    end else if (cursor_hit_c) begin
      if (state_c == EMPTY) begin
        red_c   = C_CUR;
        green_c = C_CUR;
        blue_c  = C_CUR;
      end else begin
        red_c   = mark_r_c | C_CUR;
        green_c = mark_g_c | C_CUR;
        blue_c  = mark_b_c | C_CUR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Red   <= '0;
      bus.Green <= '0;
      bus.Blue  <= '0;
    end else begin
      bus.Red   <= red_c;
      bus.Green <= green_c;
      bus.Blue  <= blue_c;
    end
  end
endmodule

// File: tb/tb_grid_color_controller.sv
// Randomised and directed checks of two grid controller configurations (3x3 and 4x2) against a frame-level model.
module tb_grid_color_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  grid_color_controller_if #(.COLOR_W(3)) bus0 ();
  grid_color_controller_if #(.COLOR_W(3)) bus1 ();

  grid_color_controller dut0 (.clk(clk), .rst(rst), .bus(bus0));
  grid_color_controller #(.COLS(4), .ROWS(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int errors = 0;

  int x, y, ccol, crow, wcol, wrow, wdata;
  bit fs, we, clr;

  // Model state: board contents per configuration, blink phase, and the pixel in flight
  int mc [2][16][16];
  int mcnt;
  bit mblink;
  int ppx, ppy;

  function automatic int cols_of(int d); return (d == 0) ? 3 : 4; endfunction
  function automatic int rows_of(int d); return (d == 0) ? 3 : 2; endfunction

  function automatic logic [8:0] ref_color(int d, int px, int py, int cc, int cr, bit blink);
    int cols, rows, cw, ch, c, r, st;
    logic [8:0] mark;
    cols = cols_of(d);
    rows = rows_of(d);
    cw = 640 / cols;
    ch = 480 / rows;
    if (px >= 640 || py >= 480) return 9'b0;
    if ((px % cw == 0 && px / cw >= 1 && px / cw <= cols - 1) ||
        (py % ch == 0 && py / ch >= 1 && py / ch <= rows - 1)) return 9'b0;
    c = px / cw; if (c > cols - 1) c = cols - 1;
    r = py / ch; if (r > rows - 1) r = rows - 1;
    st = mc[d][c][r];
    case (st)
      1:       mark = 9'b111_000_000;
      2:       mark = 9'b000_000_111;
      3:       mark = 9'b000_111_000;
      default: mark = 9'b001_001_001;
    endcase
    if (blink && cc < cols && cr < rows && cc == c && cr == r)
      return (st == 0) ? 9'b010_010_010 : (mark | 9'b010_010_010);
    return mark;
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 16; c++)
        for (int r = 0; r < 16; r++) mc[d][c][r] = 0;
  endtask

  task automatic drive();
    bus0.Xpos = 16'(x);         bus1.Xpos = 16'(x);
    bus0.Ypos = 16'(y);         bus1.Ypos = 16'(y);
    bus0.frame_start = fs;      bus1.frame_start = fs;
    bus0.cursor_col = 4'(ccol); bus1.cursor_col = 4'(ccol);
    bus0.cursor_row = 4'(crow); bus1.cursor_row = 4'(crow);
    bus0.cell_we = we;          bus1.cell_we = we;
    bus0.cell_col = 4'(wcol);   bus1.cell_col = 4'(wcol);
    bus0.cell_row = 4'(wrow);   bus1.cell_row = 4'(wrow);
    bus0.cell_data = 2'(wdata); bus1.cell_data = 2'(wdata);
    bus0.clear_board = clr;     bus1.clear_board = clr;
  endtask

  // One clock: predict the colour emerging at this edge, advance the model, compare
  task automatic step();
    logic [8:0] e0, e1;
    drive();
    e0 = rst ? 9'b0 : ref_color(0, ppx, ppy, ccol, crow, mblink);
    e1 = rst ? 9'b0 : ref_color(1, ppx, ppy, ccol, crow, mblink);
    if (rst) begin
      model_clear();
      mcnt = 0; mblink = 1'b1; ppx = 0; ppy = 0;
    end else begin
      if (clr) model_clear();
      else if (we)
        for (int d = 0; d < 2; d++)
          if (wcol < cols_of(d) && wrow < rows_of(d)) mc[d][wcol][wrow] = wdata;
      if (fs) begin
        mcnt++;
        if (mcnt == 30) begin mcnt = 0; mblink = !mblink; end
      end
      ppx = x; ppy = y;
    end
    @(posedge clk); #1;
    check("rgb_3x3", {bus0.Red, bus0.Green, bus0.Blue}, e0);
    check("rgb_4x2", {bus1.Red, bus1.Green, bus1.Blue}, e1);
  endtask

  task automatic idle(); we = 0; fs = 0; clr = 0; endtask

  task automatic settle(input int nx, input int ny);
    x = nx; y = ny; idle(); step(); step();
  endtask

  task automatic write_cell(input int c, input int r, input int dat);
    we = 1; wcol = c; wrow = r; wdata = dat; step(); we = 0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin fs = 1; step(); fs = 0; step(); end
  endtask

  task automatic check_empty_board(input string tag);
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 3; r++) begin
        settle(c * 213 + 100, r * 160 + 80);
        check(tag, {bus0.Red, bus0.Green, bus0.Blue}, 9'b001_001_001);
      end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 2; r++) begin
        settle(c * 160 + 80, r * 240 + 100);
        check(tag, {bus1.Red, bus1.Green, bus1.Blue}, 9'b001_001_001);
      end
  endtask

  initial begin
    x = 0; y = 0; ccol = 15; crow = 15; wcol = 0; wrow = 0; wdata = 0;
    idle();
    model_clear(); mcnt = 0; mblink = 1'b1; ppx = 0; ppy = 0;

    rst = 1; step(); step(); step();
    check("reset_rgb", {bus0.Red, bus0.Green, bus0.Blue}, 9'b0);
    rst = 0;

    settle(213, 50);
    check("line_x213", {bus0.Red, bus0.Green, bus0.Blue}, 9'b000_000_000);
    settle(100, 50);
    check("bg_100_50", {bus0.Red, bus0.Green, bus0.Blue}, 9'b001_001_001);
    settle(639, 50);
    check("x639_not_line", {bus0.Red, bus0.Green, bus0.Blue}, 9'b001_001_001);
    settle(640, 50);
    check("out_of_area", {bus0.Red, bus0.Green, bus0.Blue}, 9'b000_000_000);

    write_cell(1, 1, 1);
    settle(300, 200);
    check("cell_a", {bus0.Red, bus0.Green, bus0.Blue}, 9'b111_000_000);
    write_cell(3, 1, 2);
    settle(300, 200);
    check("col3_ignored_a", {bus0.Red, bus0.Green, bus0.Blue}, 9'b111_000_000);
    settle(500, 200);
    check("col3_ignored_bg", {bus0.Red, bus0.Green, bus0.Blue}, 9'b001_001_001);

    ccol = 0; crow = 0;
    settle(100, 50);
    check("cursor_on", {bus0.Red, bus0.Green, bus0.Blue}, 9'b010_010_010);
    frames(30);
    settle(100, 50);
    check("cursor_off_30", {bus0.Red, bus0.Green, bus0.Blue}, 9'b001_001_001);
    frames(30);
    settle(100, 50);
    check("cursor_on_60", {bus0.Red, bus0.Green, bus0.Blue}, 9'b010_010_010);
    ccol = 1; crow = 1;
    settle(300, 200);
    check("cursor_on_a", {bus0.Red, bus0.Green, bus0.Blue}, 9'b111_010_010);
    ccol = 15; crow = 15;

    write_cell(2, 2, 3);
    settle(500, 400);
    check("cell_win", {bus0.Red, bus0.Green, bus0.Blue}, 9'b000_111_000);
    we = 1; clr = 1; wcol = 0; wrow = 0; wdata = 2; step(); idle();
    check_empty_board("clear_wins");

    settle(160, 10);
    check("l4_x160", {bus1.Red, bus1.Green, bus1.Blue}, 9'b0);
    settle(320, 10);
    check("l4_x320", {bus1.Red, bus1.Green, bus1.Blue}, 9'b0);
    settle(480, 10);
    check("l4_x480", {bus1.Red, bus1.Green, bus1.Blue}, 9'b0);
    settle(10, 240);
    check("l4_y240", {bus1.Red, bus1.Green, bus1.Blue}, 9'b0);
    write_cell(3, 0, 2);
    settle(639, 10);
    check("l4_x639_col3", {bus1.Red, bus1.Green, bus1.Blue}, 9'b000_000_111);

    write_cell(0, 0, 1); write_cell(2, 1, 2);
    x = 100; y = 50;
    rst = 1; step(); step(); step();
    check("rst_mid_3x3", {bus0.Red, bus0.Green, bus0.Blue}, 9'b0);
    check("rst_mid_4x2", {bus1.Red, bus1.Green, bus1.Blue}, 9'b0);
    rst = 0;
    check_empty_board("rst_cleared");

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       x = 213 * int'($urandom_range(0, 3));
        1:       x = 160 * int'($urandom_range(0, 4));
        default: x = int'($urandom_range(0, 700));
      endcase
      case ($urandom_range(0, 3))
        0:       y = 160 * int'($urandom_range(0, 3));
        1:       y = 240 * int'($urandom_range(0, 2));
        default: y = int'($urandom_range(0, 520));
      endcase
      fs    = ($urandom_range(0, 3) == 0);
      we    = ($urandom_range(0, 3) == 0);
      wcol  = int'($urandom_range(0, 4));
      wrow  = int'($urandom_range(0, 3));
      wdata = int'($urandom_range(0, 3));
      clr   = ($urandom_range(0, 99) == 0);
      ccol  = int'($urandom_range(0, 4));
      crow  = int'($urandom_range(0, 3));
      rst   = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/grid_color_controller.md
GRID_COLOR_CONTROLLER -- requirements
Module: grid_color_controller

Interface
REQ-001 SHALL have parameter COLS, default 3, meaning grid columns, legal range 1..16.
REQ-002 SHALL have parameter ROWS, default 3, meaning grid rows, legal range 1..16.
REQ-003 SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-004 SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-005 SHALL have parameter COLOR_W, default 3, meaning bits per colour channel.
REQ-006 SHALL have parameter BLINK_FRAMES, default 30, meaning frames per cursor blink half-period, minimum 1.
REQ-007 SHALL have port clk, input, 1 bit, meaning the single clock.
REQ-008 SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-009 SHALL have port Xpos, input, 16 bits, meaning current pixel column.
REQ-010 SHALL have port Ypos, input, 16 bits, meaning current pixel row.
REQ-011 SHALL have port frame_start, input, 1 bit, meaning a one-clock pulse per frame.
REQ-012 SHALL have ports cursor_col and cursor_row, input, 4 bits each, meaning the selected cell.
REQ-013 SHALL have ports cell_we (1), cell_col (4), cell_row (4) and cell_data (2), input, meaning a cell-state write port.
REQ-014 SHALL have port clear_board, input, 1 bit, meaning set all cells to empty.
REQ-015 SHALL have ports Red, Green and Blue, output, COLOR_W bits each, meaning the pixel colour.

Function
REQ-016 SHALL define cell width CW = H_RES/COLS and cell height CH = V_RES/ROWS using integer division; with defaults CW = 213 and CH = 160.
REQ-017 SHALL treat a pixel as a grid line when Xpos == k*CW for k in 1..COLS-1, or Ypos == k*CH for k in 1..ROWS-1.
REQ-018 SHALL compute the cell column as the largest c with c*CW <= Xpos, clamped to COLS-1; the cell row SHALL be computed the same way using CH and ROWS-1.
REQ-019 SHALL hold a COLS*ROWS array of 2-bit cell states (EMPTY=0, A=1, B=2, WIN=3).
REQ-020 SHALL write cell_data into cell (cell_col, cell_row) on any clock with cell_we=1, effective for pixels sampled from the next clock onward.
REQ-021 SHALL ignore writes with cell_col >= COLS or cell_row >= ROWS.
REQ-022 SHALL clear all cells to EMPTY in one clock when clear_board=1; clear SHALL win over a simultaneous write.
REQ-023 SHALL count frame_start pulses and toggle blink_on every BLINK_FRAMES pulses, then restart the count at 0.
REQ-024 SHALL produce a colour priority, highest first:
  - outside active area (Xpos >= H_RES or Ypos >= V_RES): all channels 0
  - grid line: all channels 0
  - cursor cell with blink_on=1 and cell EMPTY: all channels 3'b010
  - cursor cell with blink_on=1 and cell occupied: that cell's mark colour OR 3'b010 on every channel
  - cell A: Red all ones, Green 0, Blue 0
  - cell B: Red 0, Green 0, Blue all ones
  - cell WIN: Red 0, Green all ones, Blue 0
  - cell EMPTY: all channels 3'b001
REQ-025 SHALL apply the 3'b010/3'b001 constants zero-extended for COLOR_W > 3 and truncated to the LSBs for COLOR_W < 3.
REQ-026 SHALL show no cursor when cursor_col >= COLS or cursor_row >= ROWS.
REQ-027 SHALL pipeline the datapath in two stages, giving a fixed latency of 2 clocks from Xpos/Ypos to Red/Green/Blue:
  - stage 1: register line flag, out-of-area flag, column and row indices
  - stage 2: register the colour, using cell state, cursor and blink_on at the stage-2 clock

Reset
REQ-028 SHALL, while rst=1, drive Red/Green/Blue to 0 from the next clock onward.
REQ-029 SHALL, while rst=1, clear all cells to EMPTY, clear both pipeline stages, set the blink count to 0 and set blink_on=1.
REQ-030 SHALL treat rst asserted mid-frame the same as power-up; the first valid colour SHALL appear 2 clocks after rst deasserts.
REQ-031 SHALL give rst priority over cell_we, clear_board and frame_start.

Structure
REQ-032 SHALL place the cell_state_t enum (EMPTY/A/B/WIN) and the 3-bit colour constants (LINE, BG, CURSOR) in the shared package grid_pkg.
REQ-033 SHALL implement the frame counter and blink_on toggle in the sub-module grid_blink_timer (clk, rst, frame_start, blink_on).

Verification
REQ-034 SHALL cover defaults after reset: Xpos=213, Ypos=50 gives RGB=000/000/000 two clocks later; Xpos=100, Ypos=50 gives RGB=001/001/001.
REQ-035 SHALL cover a write: cell_we with (col 1, row 1, data 1), then Xpos=300, Ypos=200 gives RGB=111/000/000; a write to col 3 leaves all cells unchanged.
REQ-036 SHALL cover the cursor: cursor=(0,0) with blink_on=1 gives 010/010/010 at (100,50); after 30 frame_start pulses the same pixel gives 001/001/001; after 60 pulses it gives 010/010/010.
REQ-037 SHALL cover clear_board and cell_we asserted on the same clock: every cell reads EMPTY afterwards.
REQ-038 SHALL cover COLS=4, ROWS=2: lines appear at X=160/320/480 and Y=240, and Xpos=639 maps to column 3.
REQ-039 SHALL cover rst asserted mid-frame with board populated: outputs are 0 while rst=1, and all cells are EMPTY after release.
